tdm_link: RTL and testbench

Parametrised time-division-multiplexed link for the MUX/DMUX data-transmission experiments. CH parallel channels of W bits are snapshotted, serialised one channel per clock onto a shared W-bit lane by a scanning mux, and redistributed by a demux into a registered CH×W output word. It supports one-shot frames with a start/busy/done handshake and free-running continuous scanning. With the defaults CH=8 and W=1, it is the clocked successor of the combinational 8-way transmission path.

---
 rtl/tdm_link.sv | 147 ++++++++++++++
 tb/tb_tdm_link.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_link.sv
// Time-division-multiplexed link: snapshots CH channels of W bits, scans them
// one per clock onto a shared lane, and rebuilds the frame in a registered
// receiver that publishes complete frames on oData with a one-cycle done.
//
// Handshake: in single mode a frame starts when start=1 is sampled while idle.
// In continuous mode frames start whenever en=1 is sampled while idle or at
// a frame boundary. busy covers the frame in flight. done pulses on the single
// edge that commits a complete frame to oData.
module tdm_link #(
    parameter int CH = 8,
    parameter int W  = 1,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            start,
    input  logic            en,
    input  logic [CH*W-1:0] iData,
    output logic            busy,
    output logic            done,
    output logic [CH*W-1:0] oData,
    output logic [W-1:0]    link_data,
    output logic [SW-1:0]   link_sel,
    output logic            link_vld
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   cnt;
    logic [CH*W-1:0] snap;
    logic [CH*W-1:0] shadow;
    logic [CH*W-1:0] frame_word;
    logic            frame_start;
    logic            wrap;
    logic            last_ch;
    logic            rx_last;

    assign last_ch = (cnt == SW'(CH - 1));
    assign rx_last = link_vld && (link_sel == SW'(CH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; mode/en only matter in IDLE and at the frame boundary.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        wrap        = 1'b0;
        case (state)
            IDLE: begin
                if ((!mode && start) || (mode && en)) begin
                    frame_start = 1'b1;
                    state_nxt   = SCAN;
                end
            end
            SCAN: begin
                if (last_ch) begin
                    if (mode && en) begin
                        wrap = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transmitter: snapshot, channel counter, lane drive and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            snap      <= '0;
            link_data <= '0;
            link_sel  <= '0;
            link_vld  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (frame_start || wrap) begin
                snap <= iData;
                cnt  <= '0;
            end else if (state == SCAN && !last_ch) begin
                cnt <= cnt + 1'b1;
            end

            if (state == SCAN) begin
                link_data <= snap[cnt*W +: W];
                link_sel  <= cnt;
                link_vld  <= 1'b1;
            end else if (state == DRAIN) begin
                link_vld <= 1'b0;
            end

            // A back-to-back continuous frame already in SCAN keeps busy high.
            if (frame_start) begin
                busy <= 1'b1;
            end else if (rx_last && state != SCAN) begin
                busy <= 1'b0;
            end
        end
    end

    // The last channel is taken straight off the lane so the frame commits
    // on the same edge it arrives.
    always_comb begin
        frame_word = shadow;
        frame_word[(CH-1)*W +: W] = link_data;
    end

    // Receiver: demux lane into shadow, commit whole frames to oData.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            oData  <= '0;
            done   <= 1'b0;
        end else begin
            if (link_vld) begin
                shadow[link_sel*W +: W] <= link_data;
            end
            if (rx_last) begin
                oData <= frame_word;
                done  <= 1'b1;
            end else begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_link.sv
// Bench for tdm_link: a default instance (CH=8, W=1) and a wide instance
// (CH=4, W=8). Expected frames and lane beats are queued by the stimulus; a
// negedge monitor pops and compares whenever the DUTs present output.
module tb_tdm_link;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default instance signals.
    logic       a_mode, a_start, a_en;
    logic [7:0] a_idata;
    logic       a_busy, a_done;
    logic [7:0] a_odata;
    logic [0:0] a_ldata;
    logic [2:0] a_lsel;
    logic       a_lvld;

    // Wide instance signals.
    logic        b_mode, b_start, b_en;
    logic [31:0] b_idata;
    logic        b_busy, b_done;
    logic [31:0] b_odata;
    logic [7:0]  b_ldata;
    logic [1:0]  b_lsel;
    logic        b_lvld;

    int tests = 0;
    int failed = 0;

    logic [7:0]  exp_a_q[$];
    logic [3:0]  lane_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [7:0]  a_prev = '0;
    logic [31:0] b_prev = '0;
    logic [31:0] b_frames[4];

    tdm_link u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .start(a_start), .en(a_en),
        .iData(a_idata), .busy(a_busy), .done(a_done), .oData(a_odata),
        .link_data(a_ldata), .link_sel(a_lsel), .link_vld(a_lvld)
    );

    tdm_link #(.CH(4), .W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .start(b_start), .en(b_en),
        .iData(b_idata), .busy(b_busy), .done(b_done), .oData(b_odata),
        .link_data(b_ldata), .link_sel(b_lsel), .link_vld(b_lvld)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        tests++;
        failed++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Monitor: compare lane beats and committed frames against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_lvld) begin
                if (lane_a_q.size() == 0) unexpected("a_lane", {a_lsel, a_ldata});
                else check("a_lane", {a_lsel, a_ldata}, lane_a_q.pop_front());
            end
            if (a_done) begin
                if (exp_a_q.size() == 0) unexpected("a_frame", a_odata);
                else check("a_frame", a_odata, exp_a_q.pop_front());
            end
            if (b_done) begin
                if (exp_b_q.size() == 0) unexpected("b_frame", b_odata);
                else check("b_frame", b_odata, exp_b_q.pop_front());
            end
            check("a_odata_only_on_done", (a_odata !== a_prev) && !a_done, 1'b0);
            check("b_odata_only_on_done", (b_odata !== b_prev) && !b_done, 1'b0);
        end
        a_prev <= a_odata;
        b_prev <= b_odata;
    end

    // Single frame on the default instance; optional extra start pulse sampled
    // at edge g (0 = none), which must be ignored.
    task automatic a_frame(input logic [7:0] d, input int g);
        int done_at;
        int ndone;
        int busy_cyc;
        done_at  = -1;
        ndone    = 0;
        busy_cyc = 0;
        a_mode   = 1'b0;
        a_en     = 1'($urandom_range(0, 1));
        a_idata  = d;
        a_start  = 1'b1;
        exp_a_q.push_back(d);
        for (int k = 0; k < 8; k++) lane_a_q.push_back({3'(k), d[k]});
        @(posedge clk); #1;
        a_start = 1'b0;
        a_idata = 8'($urandom);
        if (a_busy) busy_cyc++;
        for (int n = 1; n <= 12; n++) begin
            if (n == g) begin
                a_start = 1'b1;
                a_idata = 8'($urandom);
            end else begin
                a_start = 1'b0;
            end
            @(posedge clk); #1;
            if (a_busy) busy_cyc++;
            if (a_done) begin
                ndone++;
                done_at = n;
            end
        end
        a_start = 1'b0;
        check("a_done_count", ndone, 1);
        check("a_done_latency", done_at, 9);
        check("a_busy_cycles", busy_cyc, 9);
    endtask

    // Single frame on the wide instance; iData is trashed right after start.
    task automatic b_single(input logic [31:0] d);
        int done_at;
        int ndone;
        done_at = -1;
        ndone   = 0;
        b_mode  = 1'b0;
        b_en    = 1'b0;
        b_idata = d;
        b_start = 1'b1;
        exp_b_q.push_back(d);
        @(posedge clk); #1;
        b_start = 1'b0;
        b_idata = 32'hFFFF_FFFF;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (b_done) begin
                ndone++;
                done_at = n;
            end
        end
        check("b_single_done_count", ndone, 1);
        check("b_single_latency", done_at, 5);
    endtask

    // Continuous scan of nfr frames from b_frames; next frame is presented
    // just before each boundary, garbage otherwise; en drops before the last.
    task automatic b_cont(input int nfr);
        int ndone;
        int first;
        int last;
        int gaps;
        ndone = 0;
        first = -1;
        last  = -1;
        gaps  = 0;
        for (int k = 0; k < nfr; k++) exp_b_q.push_back(b_frames[k]);
        b_mode  = 1'b1;
        b_en    = 1'b1;
        b_start = 1'b0;
        b_idata = b_frames[0];
        for (int n = 0; n <= 4*nfr + 3; n++) begin
            @(posedge clk); #1;
            if (b_done) begin
                if (first < 0) first = n;
                else check("b_done_period", n - last, 4);
                last = n;
                ndone++;
            end
            if (n >= 1 && n <= 4*nfr && !b_lvld) gaps++;
            if (n == 4*nfr) check("b_busy_last_frame", b_busy, 1'b1);
            if (n == 4*nfr + 1) check("b_busy_cleared", b_busy, 1'b0);
            if (n % 4 == 3) begin
                if ((n + 1) / 4 < nfr) b_idata = b_frames[(n + 1) / 4];
                else b_en = 1'b0;
            end else begin
                b_idata = $urandom;
            end
        end
        check("b_first_done", first, 5);
        check("b_done_count", ndone, nfr);
        check("b_lane_gaps", gaps, 0);
        check("b_idle_vld", b_lvld, 1'b0);
        check("b_idle_busy", b_busy, 1'b0);
        b_mode = 1'b0;
    endtask

    // Reset asserted five edges into a frame of all ones.
    task automatic a_mid_reset();
        int ndone;
        ndone   = 0;
        a_mode  = 1'b0;
        a_idata = 8'hFF;
        a_start = 1'b1;
        for (int k = 0; k < 8; k++) lane_a_q.push_back({3'(k), 1'b1});
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", a_busy, 1'b0);
        check("rst_mid_odata", a_odata, 8'h00);
        check("rst_mid_vld", a_lvld, 1'b0);
        check("rst_mid_done", a_done, 1'b0);
        lane_a_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (a_done) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        check("rst_mid_odata_after", a_odata, 8'h00);
        check("rst_mid_busy_after", a_busy, 1'b0);
    endtask

    // Stimulus sequence and final report.
    initial begin
        a_mode = 1'b0; a_en = 1'b0; a_start = 1'b1; a_idata = 8'hA5;
        b_mode = 1'b0; b_en = 1'b0; b_start = 1'b1; b_idata = 32'hA5A5_A5A5;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_a_busy", a_busy, 1'b0);
            check("rst_a_done", a_done, 1'b0);
            check("rst_a_odata", a_odata, 8'h00);
            check("rst_a_lane", {a_lvld, a_lsel, a_ldata}, 5'h00);
            check("rst_b_busy", b_busy, 1'b0);
            check("rst_b_odata", b_odata, 32'h0);
            check("rst_b_lane", {b_lvld, b_lsel, b_ldata}, 11'h000);
        end
        a_start = 1'b0;
        b_start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        a_frame(8'b1011_0010, 0);
        a_frame(8'h5C, 3);
        for (int i = 0; i < 8; i++) a_frame(8'($urandom), $urandom_range(1, 9));

        b_single(32'h4433_2211);

        b_frames[0] = 32'h0302_0100;
        b_frames[1] = 32'h0706_0504;
        b_cont(2);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) b_frames[k] = $urandom;
        b_cont(4);

        a_mid_reset();

        check("a_frames_left", exp_a_q.size(), 0);
        check("a_lane_left", lane_a_q.size(), 0);
        check("b_frames_left", exp_b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
